// File: rtl/mux_accumulator.sv
// Saturating accumulator for the operand-mux sample stream.
// Sums a programmed number of signed samples and offers the result on a valid/ready port.
module mux_accumulator #(
  parameter int N     = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_sat,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_nextState;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_sat;

  logic               w_accept;
  logic               w_lastAccept;
  logic [ACC_W-1:0]   w_sext;
  logic [ACC_W:0]     w_sum;
  logic               w_posOvf;
  logic               w_negOvf;
  logic [ACC_W-1:0]   w_satSum;

  // One guard bit is enough: the two sign bits disagree exactly on overflow.
  assign w_sext   = {{(ACC_W-N){in_data[N-1]}}, in_data};
  assign w_sum    = {r_acc[ACC_W-1], r_acc} + {w_sext[ACC_W-1], w_sext};
  assign w_posOvf = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
  assign w_negOvf =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
  assign w_satSum = w_posOvf ? MAX_POS :
                    w_negOvf ? MIN_NEG : w_sum[ACC_W-1:0];

  assign w_accept     = (r_state == ACCUM) && in_valid;
  assign w_lastAccept = w_accept && (r_count == CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_sat     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_lastAccept) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_data  = r_acc;
        res_sat   = r_sat;
        if (res_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // len is captured only on an accepted start, so it may change freely mid-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_count <= len;
            r_sat   <= 1'b0;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_satSum;
            r_count <= r_count - CNT_ONE;
            if (w_posOvf || w_negOvf) begin
              r_sat <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_accumulator.sv
// Randomized self-checking bench for mux_accumulator.
// Expected sums come from a clamp-after-every-sample integer model of the sample queue.
module tb_mux_accumulator;

  localparam int N     = 16;
  localparam int ACC_W = 20;
  localparam int CNT_W = 8;
  localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_sat;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int sampleQ[$];

  mux_accumulator #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .res_data (res_data),
    .res_sat  (res_sat),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer running sum, clamped to the signed ACC_W range after each sample.
  task automatic modelSum(output logic [ACC_W-1:0] expData, output logic expSat);
    longint sum;
    sum    = 0;
    expSat = 1'b0;
    foreach (sampleQ[i]) begin
      sum = sum + longint'(sampleQ[i]);
      if (sum > MAXV) begin
        sum    = MAXV;
        expSat = 1'b1;
      end else if (sum < MINV) begin
        sum    = MINV;
        expSat = 1'b1;
      end
    end
    expData = sum[ACC_W-1:0];
  endtask

  // Runs one full transaction over sampleQ; gapPct is the chance of a stalled cycle,
  // holdCycles the result backpressure, pokeStart fires start/len while busy.
  task automatic applyStimulus(input int lenVal, input int gapPct, input int holdCycles, input bit pokeStart);
    logic [ACC_W-1:0] expData;
    logic             expSat;
    int               idx;
    int               guard;
    modelSum(expData, expSat);
    @(negedge clk);
    start     = 1'b1;
    len       = CNT_W'(lenVal);
    in_valid  = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx   = 0;
    guard = 0;
    while (idx < lenVal) begin
      checkOutput("inReadyAccum", {63'd0, in_ready}, 64'd1);
      checkOutput("busyAccum", {63'd0, busy}, 64'd1);
      checkOutput("noEarlyValid", {63'd0, res_valid}, 64'd0);
      in_valid = ($urandom_range(99) >= gapPct);
      in_data  = N'(sampleQ[idx]);
      if (pokeStart && idx == 1) begin
        start = 1'b1;
        len   = CNT_W'(lenVal + 3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (in_valid) idx++;
      guard++;
      if (guard > 2000) begin
        checkOutput("acceptTimeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput("resValidLatency", {63'd0, res_valid}, 64'd1);
    checkOutput("resData", {{(64-ACC_W){1'b0}}, res_data}, {{(64-ACC_W){1'b0}}, expData});
    checkOutput("resSat", {63'd0, res_sat}, {63'd0, expSat});
    checkOutput("inReadyDone", {63'd0, in_ready}, 64'd0);
    for (int h = 0; h < holdCycles; h++) begin
      start = pokeStart;
      @(negedge clk);
      checkOutput("holdValid", {63'd0, res_valid}, 64'd1);
      checkOutput("holdData", {{(64-ACC_W){1'b0}}, res_data}, {{(64-ACC_W){1'b0}}, expData});
      checkOutput("holdSat", {63'd0, res_sat}, {63'd0, expSat});
    end
    res_ready = 1'b1;
    start     = pokeStart;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    checkOutput("resValidDrop", {63'd0, res_valid}, 64'd0);
    checkOutput("idleBusy", {63'd0, busy}, 64'd0);
    checkOutput("idleInReady", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_resValid"}, {63'd0, res_valid}, 64'd0);
    checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_inReady"}, {63'd0, in_ready}, 64'd0);
    checkOutput({tag, "_resData"}, {{(64-ACC_W){1'b0}}, res_data}, 64'd0);
    checkOutput({tag, "_resSat"}, {63'd0, res_sat}, 64'd0);
  endtask

  initial begin
    int l;
    int pick;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetOutputs("reset");

    // Basic back-to-back run: 10 - 3 + 7 + 0 = 14.
    sampleQ = '{10, -3, 7, 0};
    applyStimulus(4, 0, 0, 1'b0);

    // Stalled input and held-off result.
    sampleQ = '{100, 100, 100};
    applyStimulus(3, 50, 5, 1'b0);

    // Positive and negative saturation with ACC_W = 20.
    sampleQ = {};
    repeat (17) sampleQ.push_back(32767);
    applyStimulus(17, 0, 1, 1'b0);
    sampleQ = {};
    repeat (17) sampleQ.push_back(-32768);
    applyStimulus(17, 0, 1, 1'b0);

    // Zero length, then starts fired mid-run and on the handshake cycle.
    sampleQ = {};
    applyStimulus(0, 0, 0, 1'b0);
    sampleQ = '{5, 6, 7, 8, 9};
    applyStimulus(5, 30, 2, 1'b1);

    // Reset with two samples already accepted.
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(5);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = N'(1000);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetOutputs("midRunReset");
    sampleQ = '{-1};
    applyStimulus(1, 0, 0, 1'b0);

    // Random runs, biased toward extreme samples so clamping recurs.
    for (int r = 0; r < 25; r++) begin
      l = $urandom_range(24);
      sampleQ = {};
      for (int s = 0; s < l; s++) begin
        pick = $urandom_range(3);
        if (pick == 0)      sampleQ.push_back(32767);
        else if (pick == 1) sampleQ.push_back(-32768);
        else                sampleQ.push_back(int'($urandom_range(65535)) - 32768);
      end
      applyStimulus(l, $urandom_range(40), $urandom_range(3), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_accumulator.md
Name: mux_accumulator

Overview:
- Downstream consumer of the 3-to-1 operand mux (a / b / zero). Takes the mux's N-bit output as a stream of signed samples and accumulates a programmed number of them into a saturating sum.
- Presents the sum on a valid/ready result port.
- Sits between the operand-select stage and the result writeback or readout logic on the PYNQ-Z2 fabric.

Parameters:
- N, 16, width of incoming sample (matches mux width); two's complement signed.
- ACC_W, 24, accumulator and result width; must be > N.
- CNT_W, 8, width of length field; max run length 2^CNT_W - 1 samples.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run; honoured only in IDLE.
- len  input  CNT_W  samples to accumulate; sampled on accepted start.
- in_data  input  N  sample from mux output, signed.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- res_data  output  ACC_W  accumulated signed sum.
- res_sat  output  1  sticky: saturation occurred during this run.
- res_valid  output  1  result available.
- res_ready  input  1  downstream takes result.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- FSM states: IDLE, ACCUM, DONE. Reset sets state to IDLE.
- Reset values: acc = 0, count = 0, res_sat = 0, res_valid = 0, in_ready = 0, busy = 0, res_data = 0.
- Reset mid-run discards the partial sum. No result is emitted.
- IDLE:
  - in_ready = 0, busy = 0.
  - On start: count <= len, acc <= 0, sat <= 0.
  - If len == 0, go to DONE with res_data = 0 and res_sat = 0. Otherwise go to ACCUM.
- ACCUM:
  - in_ready = 1 (combinational from state), busy = 1.
  - A sample is accepted when in_valid && in_ready.
  - On accept: acc <= sat_add(acc, sext(in_data)); count <= count - 1.
  - If count == 1 at accept, go to DONE on the next edge.
  - in_valid low stalls the run with no state change. No timeout.
- DONE:
  - res_valid = 1, res_data = acc, res_sat = sticky flag, in_ready = 0.
  - Outputs hold stable while res_ready = 0.
  - On res_valid && res_ready, go to IDLE and drop res_valid on the next cycle.
- Latency: res_valid asserts exactly 1 cycle after the edge that accepts the last sample. Throughput is 1 sample/cycle.
- sat_add:
  - Sign-extend in_data to ACC_W, then add in ACC_W+1 bits.
  - Positive overflow clamps to 2^(ACC_W-1) - 1. Negative overflow clamps to -2^(ACC_W-1).
  - Either clamp sets the sticky sat flag. The clamped value continues accumulating.
- start while busy (ACCUM or DONE) is ignored, including start in the same cycle as the res_ready handshake. A new run needs start in a later IDLE cycle.
- len is not re-sampled during a run.
- Zero samples from the mux (sel outside 00/01) are accumulated like any other sample and consume count.

Test Plan:
- Basic: start with len = 4, samples 10, -3, 7, 0 back-to-back, res_ready = 1 → res_valid one cycle after the 4th accept, res_data = 14, res_sat = 0, then IDLE.
- Stall/backpressure: len = 3, in_valid gapped (1, 0, 0, 1, 0, 1), samples 100 each, res_ready held 0 for 5 cycles → in_ready high throughout ACCUM; res_data = 300 held stable while waiting; IDLE one cycle after res_ready = 1.
- Saturation (ACC_W = 20): len = 17, all samples 0x7FFF → res_data = 524287, res_sat = 1.
- Negative saturation (ACC_W = 20): len = 17, all samples 0x8000 → res_data = -524288 (0x80000), res_sat = 1.
- Zero length and ignored start: len = 0 → res_valid the next cycle with res_data = 0. start pulsed during ACCUM and on the DONE handshake cycle → no restart, count unaffected.
- Reset mid-run: len = 5, accept 2 samples, assert rst for 1 cycle → all outputs 0, state IDLE. A new run with len = 1, sample -1 gives res_data = -1 with no residue from the aborted run.
